fp_accumulator: RTL and testbench
=================================

Name: fp_accumulator

Overview:
- Streaming IEEE-754 single-precision accumulator; sits directly downstream of fp_adder and instantiates it in a feedback loop (acc + operand -> acc).
- Sums a packet of operands, one per cycle, delimited by in_last, and presents one registered sum per packet on a valid/ready output.
- Flags packets containing Inf/NaN; fp_adder results are not guaranteed for exponent 255.

Parameters:
- MAX_TERMS, 256, maximum beats per packet; reaching it forces packet termination.
- CNT_W, $clog2(MAX_TERMS+1), width of the term counter; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  32  operand, IEEE-754 single.
- in_last  input  1  final beat of packet; qualified by in_valid.
- out_valid  output  1  packet result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  32  packet sum.
- out_count  output  CNT_W  number of beats summed.
- out_special  output  1  an operand or partial sum had exponent 255; out_sum is undefined.
- out_trunc  output  1  packet closed by MAX_TERMS, not by in_last.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=32'h0000_0000, count=0, out_valid=0, out_sum=0, out_count=0, out_special=0, out_trunc=0. in_ready is combinational from state, so it reads 1 during reset. Upstream must not assert in_valid while rst_n=0.
- States:
  - IDLE: count=0.
  - ACC: at least 1 beat accepted.
  - HOLD: result presented.
- in_ready = (state != HOLD).
- Beat accepted when in_valid && in_ready:
  - acc <= fp_adder(acc, in_data).
  - count <= count+1.
  - special_sticky |= (in_data[30:23]==8'hFF) | (sum[30:23]==8'hFF).
- Termination: the accepted beat has in_last=1, or count+1==MAX_TERMS.
  - Next cycle: state=HOLD, out_valid=1, out_sum = the new sum, out_count = count+1, out_special = the updated sticky.
  - out_trunc = 1 only if in_last=0.
  - Latency is one cycle from the last beat's accept edge to out_valid.
- Otherwise IDLE->ACC and ACC->ACC.
- HOLD: out_* held stable while out_ready=0. On out_valid && out_ready: state=IDLE, acc=+0, count=0, sticky=0, out_valid=0.
- Throughput: one beat per cycle within a packet; one bubble cycle per packet (HOLD accepts nothing) unless FP_ACC_OVERLAP_EN is defined.
- A first beat is summed against +0, so a lone -0 yields +0, consistent with fp_adder round-to-nearest.
- in_last with in_valid=0 is ignored.
- Counter never exceeds MAX_TERMS; no wrap.
- Reset mid-packet discards the partial sum; no output is produced for that packet.

Optional Feature:
- Macro: FP_ACC_OVERLAP_EN.
- Defined:
  - in_ready = (state != HOLD) || out_ready.
  - A beat accepted in the same cycle as the output handshake starts a new packet: acc <= fp_adder(+0, in_data), count <= 1, sticky from that beat only.
  - Next state is ACC, or HOLD if that beat terminates.
  - Zero bubble cycles between packets.
- Undefined: behaviour as in Behaviour, with one mandatory bubble cycle in HOLD.

Decomposition:
- Package fp_pkg:
  - FP_W=32, EXP_W=8, MAN_W=23.
  - EXP_MAX=8'hFF, POS_ZERO=32'h0000_0000.
  - typedef fp32_t (packed struct: sign, exp, man).
  - typedef enum acc_state_t {IDLE, ACC, HOLD}.
  - function is_special(fp32_t).
- Sub-module: the existing combinational fp_adder (ports a, b, s), instantiated once. No new sub-module; control, counter and registers live in fp_accumulator.

Test Plan:
- Beats 3F800000, 40000000, 40400000(last), out_ready=1 -> out_valid one cycle after 3rd accept; out_sum=40C00000, out_count=3, out_special=0, out_trunc=0.
- Single beat C0A00000(last), then packet 3F800000, BF800000(last) -> out_sum=C0A00000, count=1; then out_sum=00000000, count=2.
- Result 40C00000 with out_ready=0 for 5 cycles -> out_valid=1, out_sum stable, in_ready=0 throughout; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Packet 3F800000, 7F800000(last) -> out_special=1, out_count=2; next packet 3F800000(last) -> out_special=0.
- MAX_TERMS=4, five 3F800000 beats, no last -> after 4th: out_sum=40800000, count=4, out_trunc=1; 5th beat, after the handshake, starts a new packet with count=1.
- Assert rst_n=0 after 2 beats of 40000000 -> out_valid=0 immediately; after release, 3F800000(last) -> out_sum=3F800000, count=1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision types and constants for the accumulator slice.
package fp_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam logic [FP_W-1:0]  POS_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_t;

  // Inf or NaN: the adder gives no guarantee for these encodings
  function automatic logic is_special(input fp32_t v);
    return (v.exp == EXP_MAX);
  endfunction

endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Results for Inf/NaN operands are not meaningful (an exponent-255 pattern is returned).
module fp_adder
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] s
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      n = v[i] ? 5'(26 - i) : n;
    end
    return n;
  endfunction

  fp32_t       x_s, y_s;
  logic        sub_s, inc_s;
  logic [8:0]  ex_s, ey_s, d_s, lim_s;
  logic [26:0] mx_s, my_s, my_al_s, norm_s;
  logic [27:0] raw_s;
  logic [4:0]  lz_s, sh_s;
  logic [9:0]  e_s, e_fin_s;
  logic [24:0] rnd_s;
  logic [23:0] man_s;

  // Align the smaller operand (with sticky), add/subtract, normalise, round
  always_comb begin
    if (b[FP_W-2:0] > a[FP_W-2:0]) begin
      x_s = fp32_t'(b);
      y_s = fp32_t'(a);
    end else begin
      x_s = fp32_t'(a);
      y_s = fp32_t'(b);
    end
    sub_s = x_s.sign ^ y_s.sign;
    ex_s  = (x_s.exp == 8'h00) ? 9'd1 : {1'b0, x_s.exp};
    ey_s  = (y_s.exp == 8'h00) ? 9'd1 : {1'b0, y_s.exp};
    mx_s  = {(x_s.exp != 8'h00), x_s.man, 3'b000};
    my_s  = {(y_s.exp != 8'h00), y_s.man, 3'b000};
    d_s   = ex_s - ey_s;
    if (d_s >= 9'd27) begin
      my_al_s = {26'd0, |my_s};
    end else begin
      my_al_s = (my_s >> d_s) | {26'd0, |(my_s & ~({27{1'b1}} << d_s))};
    end
    raw_s  = sub_s ? ({1'b0, mx_s} - {1'b0, my_al_s}) : ({1'b0, mx_s} + {1'b0, my_al_s});
    lz_s   = lzc27(raw_s[26:0]);
    lim_s  = ex_s - 9'd1;
    sh_s   = 5'd0;
    norm_s = raw_s[26:0];
    e_s    = {1'b0, ex_s};
    if (raw_s[27]) begin
      norm_s = raw_s[27:1] | {26'd0, raw_s[0]};
      e_s    = {1'b0, ex_s} + 10'd1;
    end else begin
      // never shift below the minimum exponent: the result goes subnormal instead
      sh_s   = ({4'd0, lz_s} < lim_s) ? lz_s : lim_s[4:0];
      norm_s = raw_s[26:0] << sh_s;
      e_s    = {1'b0, ex_s} - {5'd0, sh_s};
    end
    inc_s   = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    rnd_s   = {1'b0, norm_s[26:3]} + {24'd0, inc_s};
    e_fin_s = e_s;
    if (rnd_s[24]) begin
      man_s   = rnd_s[24:1];
      e_fin_s = e_s + 10'd1;
    end else begin
      man_s   = rnd_s[23:0];
    end
    if (is_special(fp32_t'(a)) || is_special(fp32_t'(b))) begin
      s = {1'b0, EXP_MAX, 23'h40_0000};
    end else if (raw_s == 28'd0) begin
      s = {x_s.sign & ~sub_s, 31'd0};
    end else if (e_fin_s >= 10'd255) begin
      s = {x_s.sign, EXP_MAX, 23'd0};
    end else begin
      s = {x_s.sign, (man_s[23] ? e_fin_s[7:0] : 8'h00), man_s[22:0]};
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// Packet accumulator: sums one IEEE-754 operand per cycle through fp_adder, one registered result per packet.
// Define FP_ACC_OVERLAP_EN to accept the next packet's first beat during the output handshake.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter  int MAX_TERMS = 256,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_special,
  output logic             out_trunc
);

  acc_state_t       state_r, state_nxt_s;
  logic [FP_W-1:0]  acc_r, base_acc_s, sum_s, out_sum_r;
  logic [CNT_W-1:0] count_r, base_cnt_s, cnt_inc_s, out_count_r;
  logic             sticky_r, base_sticky_s, sticky_nxt_s;
  logic             accept_s, hs_s, term_s;
  logic             out_valid_r, out_special_r, out_trunc_r;

`ifdef FP_ACC_OVERLAP_EN
  assign in_ready = (state_r != HOLD) || out_ready;
`else
  assign in_ready = (state_r != HOLD);
`endif

  assign accept_s = in_valid && in_ready;
  assign hs_s     = out_valid_r && out_ready;

  // A beat taken together with the output handshake starts from a clean packet
  assign base_acc_s    = hs_s ? POS_ZERO : acc_r;
  assign base_cnt_s    = hs_s ? {CNT_W{1'b0}} : count_r;
  assign base_sticky_s = hs_s ? 1'b0 : sticky_r;

  fp_adder u_fp_adder (
    .a (base_acc_s),
    .b (in_data),
    .s (sum_s)
  );

  assign cnt_inc_s    = base_cnt_s + CNT_W'(1'b1);
  assign sticky_nxt_s = base_sticky_s | is_special(fp32_t'(in_data)) | is_special(fp32_t'(sum_s));
  assign term_s       = accept_s && (in_last || (cnt_inc_s == CNT_W'(MAX_TERMS)));

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, ACC: begin
        if (accept_s) begin
          state_nxt_s = term_s ? HOLD : ACC;
        end else begin
          state_nxt_s = state_r;
        end
      end
      HOLD: begin
        if (hs_s) begin
          state_nxt_s = accept_s ? (term_s ? HOLD : ACC) : IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Running sum, beat counter and special-value sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= POS_ZERO;
      count_r  <= {CNT_W{1'b0}};
      sticky_r <= 1'b0;
    end else if (accept_s) begin
      acc_r    <= sum_s;
      count_r  <= cnt_inc_s;
      sticky_r <= sticky_nxt_s;
    end else if (hs_s) begin
      acc_r    <= POS_ZERO;
      count_r  <= {CNT_W{1'b0}};
      sticky_r <= 1'b0;
    end else begin
      acc_r    <= acc_r;
      count_r  <= count_r;
      sticky_r <= sticky_r;
    end
  end

  // Result registers, held until the downstream handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      out_sum_r     <= POS_ZERO;
      out_count_r   <= {CNT_W{1'b0}};
      out_special_r <= 1'b0;
      out_trunc_r   <= 1'b0;
    end else if (term_s) begin
      out_valid_r   <= 1'b1;
      out_sum_r     <= sum_s;
      out_count_r   <= cnt_inc_s;
      out_special_r <= sticky_nxt_s;
      out_trunc_r   <= ~in_last;
    end else if (hs_s) begin
      out_valid_r   <= 1'b0;
    end else begin
      out_valid_r   <= out_valid_r;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_sum     = out_sum_r;
  assign out_count   = out_count_r;
  assign out_special = out_special_r;
  assign out_trunc   = out_trunc_r;

endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator (MAX_TERMS=4): directed packets plus random packets against a real-arithmetic model.
// Adapts its ready model when FP_ACC_OVERLAP_EN is defined.
module tb_fp_accumulator;

  localparam int MAXT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_special, out_trunc;
  logic [31:0] out_sum;
  logic [2:0]  out_count;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  bit rand_rdy = 1'b0;

  // model state
  bit          m_valid = 1'b0;
  logic [31:0] m_acc = 32'h0;
  int          m_cnt = 0;
  bit          m_spec = 1'b0;
  logic [31:0] e_sum = 32'h0;
  int          e_cnt = 0;
  bit          e_spec = 1'b0;
  bit          e_trunc = 1'b0;

  fp_accumulator #(.MAX_TERMS(MAXT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_special(out_special), .out_trunc(out_trunc)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_sp(input logic [31:0] f);
    return (f[30:23] == 8'hFF);
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // round a double to the nearest single, ties to even (normal range only)
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] mm;
    logic [10:0] ef;
    if (r == 0.0) return 32'h0;
    d  = $realtobits(r);
    mm = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) mm = mm + 25'd1;
    ef = d[62:52] - 11'd896;
    if (mm[24]) begin
      mm = mm >> 1;
      ef = ef + 11'd1;
    end
    return {d[63], ef[7:0], mm[22:0]};
  endfunction

  function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  task automatic model_step();
    bit rdy;
    bit hs;
    if (!rst_n) begin
      m_valid = 1'b0; m_acc = 32'h0; m_cnt = 0; m_spec = 1'b0;
      return;
    end
    hs = m_valid && out_ready;
`ifdef FP_ACC_OVERLAP_EN
    rdy = !m_valid || out_ready;
`else
    rdy = !m_valid;
`endif
    if (hs) m_valid = 1'b0;
    if (in_valid && rdy) begin
      n_acc++;
      m_cnt++;
      if (is_sp(in_data) || m_spec) m_spec = 1'b1;
      else begin
        m_acc = add_model(m_acc, in_data);
        if (is_sp(m_acc)) m_spec = 1'b1;
      end
      if (in_last || m_cnt == MAXT) begin
        m_valid = 1'b1; e_sum = m_acc; e_cnt = m_cnt; e_spec = m_spec; e_trunc = !in_last;
        m_acc = 32'h0; m_cnt = 0; m_spec = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // per-cycle comparison against the model
  initial forever begin
    bit exp_rdy;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", out_sum, 32'h0);
      chk("rst_out_count", 32'(out_count), 32'd0);
      chk("rst_out_special", 32'(out_special), 32'd0);
      chk("rst_out_trunc", 32'(out_trunc), 32'd0);
    end else begin
`ifdef FP_ACC_OVERLAP_EN
      exp_rdy = !m_valid || out_ready;
`else
      exp_rdy = !m_valid;
`endif
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_count", 32'(out_count), 32'(e_cnt));
        chk("out_special", 32'(out_special), 32'(e_spec));
        chk("out_trunc", 32'(out_trunc), 32'(e_trunc));
        if (!e_spec) chk("out_sum", out_sum, e_sum);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
  end

  task automatic send(input logic [31:0] d, input logic l);
    int t0;
    int k;
    t0 = n_acc;
    in_valid = 1'b1; in_data = d; in_last = l;
    k = 0;
    while (n_acc == t0 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (n_acc == t0) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  function automatic logic [31:0] rnd_fp();
    if ($urandom_range(0, 39) == 0) return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom)};
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
  endfunction

  task automatic result(input string tag, input logic [31:0] s, input int c, input bit sp, input bit tr);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (!sp) chk({tag, "_sum"}, out_sum, s);
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    chk({tag, "_special"}, 32'(out_special), 32'(sp));
    chk({tag, "_trunc"}, 32'(out_trunc), 32'(tr));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; out_ready = 1'b0;
    chk("model_1p2", add_model(32'h3F80_0000, 32'h4000_0000), 32'h4040_0000);
    chk("model_tie_even", add_model(32'h3F80_0000, 32'h3380_0000), 32'h3F80_0000);
    chk("model_tie_up", add_model(32'h3F80_0001, 32'h3380_0000), 32'h3F80_0002);
    chk("model_cancel", add_model(32'h3F80_0000, 32'hBF80_0000), 32'h0000_0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(32'h3F80_0000, 1'b0); send(32'h4000_0000, 1'b0); send(32'h4040_0000, 1'b1);
    result("t1", 32'h40C0_0000, 3, 1'b0, 1'b0);

    send(32'hC0A0_0000, 1'b1);
    result("t2a", 32'hC0A0_0000, 1, 1'b0, 1'b0);
    send(32'h3F80_0000, 1'b0); send(32'hBF80_0000, 1'b1);
    result("t2b", 32'h0000_0000, 2, 1'b0, 1'b0);

    @(negedge clk);
    out_ready = 1'b0;
    send(32'h3F80_0000, 1'b0); send(32'h4000_0000, 1'b0); send(32'h4040_0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_sum", out_sum, 32'h40C0_0000);
      chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_release_valid", 32'(out_valid), 32'd0);
    chk("t3_release_in_ready", 32'(in_ready), 32'd1);

    send(32'h3F80_0000, 1'b0); send(32'h7F80_0000, 1'b1);
    result("t4a", 32'h0, 2, 1'b1, 1'b0);
    send(32'h3F80_0000, 1'b1);
    result("t4b", 32'h3F80_0000, 1, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) send(32'h3F80_0000, 1'b0);
    result("t5a", 32'h4080_0000, 4, 1'b0, 1'b1);
    send(32'h3F80_0000, 1'b0); send(32'h3F80_0000, 1'b1);
    result("t5b", 32'h4000_0000, 2, 1'b0, 1'b0);

    send(32'h4000_0000, 1'b0); send(32'h4000_0000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h3F80_0000, 1'b1);
    result("t6", 32'h3F80_0000, 1, 1'b0, 1'b0);

    rand_rdy = 1'b1;
    for (int p = 0; p < 150; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 1; b <= len; b++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        send(rnd_fp(), (b == len));
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
